elastic_pipeline: RTL and testbench
===================================

// Module: elastic_pipeline
// PURPOSE
//  Parametrised valid/ready delay line: STAGES registered stages of WIDTH-bit data.
//  Supports back-pressure with bubble collapsing, a synchronous flush and an occupancy count.
//  Replaces fixed-latency delay lines where the consumer (PPU/APU FIFOs, memory
//  arbiter) can stall. Sits between any producer/consumer pair on the clk_in domain.
// PARAMETERS
//  WIDTH   16  payload width in bits (>=1)
//  STAGES  2   number of register stages (>=1); elaboration error if 0
// PORTS
//  clk_in     input   1                      system clock, all state on posedge
//  rst_n_in   input   1                      reset, asynchronous assert, active-low
//  flush_in   input   1                      synchronous flush; discards all stages
//  in_valid   input   1                      producer has data_in
//  in_ready   output  1                      stage 0 can accept this cycle
//  data_in    input   WIDTH                  incoming payload
//  out_valid  output  1                      last stage holds valid data
//  out_ready  input   1                      consumer accepts data_out this cycle
//  data_out   output  WIDTH                  outgoing payload (= last stage data)
//  count_out  output  $clog2(STAGES+1)       number of valid stages
// BEHAVIOUR
//  - State per stage i: vld[i], dat[i]. Stage 0 is nearest the input; stage STAGES-1 drives the outputs.
//  - Reset (rst_n_in=0, async): all vld=0, all dat=0, count_out=0.
//    Outputs while in reset: out_valid=0, data_out=0, in_ready=0.
//    Reset release takes effect on the next posedge only.
//  - Stage ready: rdy[STAGES-1] = !vld[STAGES-1] | out_ready;
//    rdy[i] = !vld[i] | (vld[i+1]==0 ? 1 : rdy[i+1]), i.e. !vld[i] | rdy[i+1].
//    A stage loads when rdy[i] is true.
//  - Stage loading:
//    - Stage 0 loads data_in/in_valid.
//    - Stage i>0 loads dat[i-1]/vld[i-1].
//    - A stage that does not load holds both vld and dat.
//    - Bubbles collapse: an empty stage always advances toward the output.
//  - in_ready = rdy[0] & !flush_in & rst_n_in (combinational from out_ready).
//  - Transfer rules:
//    - input fire = in_valid & in_ready.
//    - output fire = out_valid & out_ready.
//    - out_valid = vld[STAGES-1] & !flush_in.
//    - out_valid/data_out stay stable while out_valid=1 and out_ready=0.
//  - Latency: a word accepted at edge k appears on out_valid after edge k+STAGES-1
//    with no stalls (STAGES=1: visible the cycle after acceptance).
//    Full throughput is one word per cycle.
//  - Full: count_out==STAGES and out_ready=0 -> in_ready=0.
//    Full with out_ready=1 -> in_ready=1 (simultaneous in/out fire allowed, count unchanged).
//  - count_out register: next = count + in_fire - out_fire; never exceeds STAGES,
//    never underflows. Invariant: count_out == popcount(vld).
//  - Flush (flush_in=1 at posedge):
//    - all vld cleared, count_out=0; dat may be left unchanged.
//    - No fire occurs in the flush cycle, since in_ready=0 and out_valid=0.
//    - Flush has priority over simultaneous valid/ready.
//  - Reset mid-operation: in-flight words are discarded with no output; behaviour as reset.
//  - data_out when out_valid=0: last-loaded value held; consumers must not sample it.
// TESTING
//  1 Stream STAGES=3, WIDTH=8, out_ready=1, in 0x01..0x0A back-to-back -> first out_valid
//    3 cycles after first accept; 0x01..0x0A in order, one per cycle; count_out steady at 3.
//  2 Fill with 0x11,0x22,0x33, out_ready=0 -> count_out=3, in_ready=0, data_out=0x11 held;
//    out_ready=1 with in 0x44 -> 0x11 out and 0x44 in on the same edge, count_out=3.
//  3 Bubble collapse: accept 0xAA, idle input, out_ready=0 for 5 cycles -> 0xAA reaches the
//    last stage, count_out=1, in_ready=1 throughout.
//  4 Flush with 2 words held and in_valid=1/out_ready=1 same cycle -> no fire, next cycle
//    count_out=0, out_valid=0; nothing emitted afterwards.
//  5 Assert rst_n_in low mid-stream, between edges -> out_valid=0, count_out=0 immediately;
//    release, send 0x5A -> 0x5A out after STAGES cycles, earlier words never appear.
//  6 STAGES=1: random in_valid/out_ready for 1000 cycles vs scoreboard -> order preserved,
//    no loss or duplication, count_out==popcount(vld) every cycle.

Source files
------------

// File: rtl/elastic_pipeline.sv
// Elastic valid/ready delay line of STAGES registers; empty stages always advance (bubbles collapse).
// Latency STAGES-1 edges from accept to out_valid when unstalled; in_ready drops only when every stage is full and out_ready is low.
module elastic_pipeline #(
    parameter  int WIDTH  = 16,
    parameter  int STAGES = 2,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count_out
);

    if (STAGES < 1) begin : g_bad_stages
        $error("elastic_pipeline: STAGES must be at least 1");
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_src;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  dat_q   [STAGES];
    logic [WIDTH-1:0]  dat_d   [STAGES];
    logic [WIDTH-1:0]  dat_src [STAGES];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full_run;
    logic              in_fire;
    logic              out_fire;

    // A stage can load unless it and every stage after it is full while the consumer stalls.
    always_comb begin
        full_run = 1'b1;
        rdy      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_run = full_run & vld_q[i];
            rdy[i]   = out_ready | !full_run;
        end
    end

    assign in_ready  = rdy[0] & !flush_in & rst_n_in;
    assign out_valid = vld_q[STAGES-1] & !flush_in;
    assign data_out  = dat_q[STAGES-1];
    assign count_out = count_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        vld_src    = (vld_q << 1) | STAGES'(in_valid);
        dat_src[0] = data_in;
        for (int i = 1; i < STAGES; i++) begin
            dat_src[i] = dat_q[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            vld_d[i] = rdy[i] ? vld_src[i] : vld_q[i];
            dat_d[i] = rdy[i] ? dat_src[i] : dat_q[i];
        end
        count_d = count_q + CW'(in_fire) - CW'(out_fire);
        // Flush drops occupancy only; payload registers may keep stale data.
        if (flush_in) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: a 3-stage and a 1-stage instance share stimulus; one is scored at a time
// against a queue model holding each word's stage position.
module tb_elastic_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] data_in;
    logic       ir3, ov3, ir1, ov1;
    logic [7:0] do3, do1;
    logic [1:0] cnt3;
    logic [0:0] cnt1;
    logic       sel;

    int checks = 0;
    int errors = 0;
    int accepted;
    int first_out;
    int lat;

    typedef struct {
        logic [7:0] d;
        int         pos;
    } ent_t;

    ent_t       q[$];
    logic [7:0] rx[$];
    logic [7:0] sent[$];

    elastic_pipeline #(.WIDTH(8), .STAGES(3)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .in_valid(in_valid), .in_ready(ir3), .data_in(data_in),
        .out_valid(ov3), .out_ready(out_ready), .data_out(do3), .count_out(cnt3)
    );

    elastic_pipeline #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .in_valid(in_valid), .in_ready(ir1), .data_in(data_in),
        .out_valid(ov1), .out_ready(out_ready), .data_out(do1), .count_out(cnt1)
    );

    always #5 clk = ~clk;

    function automatic int stg();
        return sel ? 1 : 3;
    endfunction

    function automatic logic [31:0] obs_ir();
        return sel ? 32'(ir1) : 32'(ir3);
    endfunction

    function automatic logic [31:0] obs_ov();
        return sel ? 32'(ov1) : 32'(ov3);
    endfunction

    function automatic logic [31:0] obs_do();
        return sel ? 32'(do1) : 32'(do3);
    endfunction

    function automatic logic [31:0] obs_cnt();
        return sel ? 32'(cnt1) : 32'(cnt3);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, want, $time);
        end
    endtask

    // Words move one stage per edge unless they sit in the full run at the output while the consumer stalls.
    task automatic model_edge(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        int   s;
        int   stuck;
        logic acc;
        s     = stg();
        stuck = 0;
        if (fl) begin
            q.delete();
        end else begin
            acc = iv && (ordy || q.size() < s);
            if (ordy) begin
                if (q.size() > 0 && q[0].pos == s - 1) q.delete(0);
            end else begin
                while (stuck < q.size() && q[stuck].pos == s - 1 - stuck) stuck++;
            end
            for (int k = stuck; k < q.size(); k++) q[k].pos = q[k].pos + 1;
            if (acc) begin
                q.push_back('{d: id, pos: 0});
                sent.push_back(id);
                accepted++;
            end
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        int   s;
        logic e_ir;
        logic e_ov;
        in_valid  = iv;
        data_in   = id;
        out_ready = ordy;
        flush     = fl;
        #2;
        s    = stg();
        e_ir = (ordy || q.size() < s) && !fl;
        e_ov = (q.size() > 0) && (q[0].pos == s - 1) && !fl;
        check("in_ready", obs_ir(), 32'(e_ir));
        check("out_valid", obs_ov(), 32'(e_ov));
        check("count_out", obs_cnt(), 32'(q.size()));
        if (e_ov) begin
            check("data_out", obs_do(), 32'(q[0].d));
            if (ordy) rx.push_back(obs_do() & 32'hFF);
        end
        @(posedge clk);
        model_edge(iv, id, ordy, fl);
        #1;
    endtask

    // Asserts reset between edges, checks the outputs collapse at once, releases on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        rx.delete();
        sent.delete();
        in_valid  = 1'b1;
        data_in   = 8'hEE;
        out_ready = 1'b1;
        flush     = 1'b0;
        #3;
        check("rst_in_ready", obs_ir(), 0);
        check("rst_out_valid", obs_ov(), 0);
        check("rst_count", obs_cnt(), 0);
        check("rst_data_out", obs_do(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel       = 1'b0;
        accepted  = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 8'h00;
        #1;
        do_reset();

        // Back-to-back stream with the consumer always ready
        first_out = -1;
        for (int n = 0; n < 16; n++) begin
            step(n < 10, 8'(n + 1), 1'b1, 1'b0);
            if (first_out < 0 && rx.size() > 0) first_out = n;
        end
        check("t1_latency", first_out, 3);
        check("t1_words", rx.size(), 10);
        for (int i = 0; i < 10; i++) check("t1_order", rx[i], i + 1);

        // Fill against a stalled consumer, then swap one word in and one out on the same edge
        rx.delete();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("t2_full_count", obs_cnt(), 3);
        check("t2_full_in_ready", obs_ir(), 0);
        check("t2_hold_data", obs_do(), 8'h11);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        check("t2_swap_words", rx.size(), 1);
        check("t2_swap_data", rx[0], 8'h11);
        check("t2_swap_count", obs_cnt(), 3);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_drain_words", rx.size(), 4);
        check("t2_drain_last", rx[3], 8'h44);

        // A lone word slides to the output stage while the consumer stalls
        rx.delete();
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        repeat (5) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            check("t3_in_ready", obs_ir(), 1);
        end
        check("t3_count", obs_cnt(), 1);
        check("t3_out_valid", obs_ov(), 1);
        check("t3_data", obs_do(), 8'hAA);
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_words", rx.size(), 1);

        // Flush with two words held and both handshakes requested in the same cycle
        rx.delete();
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        step(1'b1, 8'h63, 1'b1, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t4_count", obs_cnt(), 0);
        check("t4_out_valid", obs_ov(), 0);
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_nothing_out", rx.size(), 0);

        // Reset mid-stream, then a single fresh word
        for (int n = 0; n < 4; n++) step(1'b1, 8'(8'h70 + n), 1'b1, 1'b0);
        do_reset();
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        lat = -1;
        for (int n = 1; n <= 8; n++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (lat < 0 && rx.size() > 0) lat = n;
        end
        check("t5_latency", lat, 3);
        check("t5_words", rx.size(), 1);
        check("t5_data", rx[0], 8'h5A);

        // Single-stage instance under random handshakes
        sel = 1'b1;
        do_reset();
        accepted = 0;
        repeat (1000) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end
        check("t6_conserve", rx.size() + q.size(), accepted);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_words", rx.size(), sent.size());
        for (int i = 0; i < rx.size() && i < sent.size(); i++) check("t6_order", rx[i], sent[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
